// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder. start is the valid strobe and
// !busy is the ready: an operation is accepted on a rising clk where start && !busy.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       state;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, state
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, state
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, carry recirculated
// through a flop; parallel sum/cout registered on completion with a done pulse.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_ff_q, c_ff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_sum, fa_carry;

  full_adder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (c_ff_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_ff_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_ff_q  <= c_ff_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_ff_d  = c_ff_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        s_sh_d = {fa_sum, s_sh_q[WIDTH-1:1]};
        c_ff_d = fa_carry;
        if (cnt_q == LAST) begin
          // Counter parks at zero so it never runs past WIDTH-1.
          cnt_d   = '0;
          sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE -> RUN gives zero-gap back-to-back.
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_ff_d  = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder against a+b+cin, with a result
// queue filled at each accepted start and drained on each done pulse.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_starts = 0;
  logic [WIDTH:0] exp_q[$];

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_result", {23'd0, bus.cout, bus.sum}, 32'(exp_q.pop_front()));
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    exp_q.push_back((WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c));
    n_starts++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < 50), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int d0, t, t1, t2, sum_bad;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic op: busy for exactly WIDTH cycles, prior sum held during RUN.
    start_op(8'h5A, 8'h3C, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      check("t1_busy", 32'(bus.busy), 32'd1);
      check("t1_done_low", 32'(bus.done), 32'd0);
      check("t1_sum_hold", 32'(bus.sum), 32'd0);
      @(negedge clk);
    end
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy_off", 32'(bus.busy), 32'd0);
    check("t1_sum", 32'(bus.sum), 32'h96);
    @(negedge clk);
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_idle", 32'(bus.state), 32'd0);

    // Carry chains.
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done();
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done();

    // start while busy is ignored.
    d0 = n_done;
    start_op(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h77;
    bus.b     = 8'h11;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    check("t3_one_done", 32'(n_done - d0), 32'd1);
    check("t3_sum", 32'(bus.sum), 32'h30);

    // Back-to-back with start held high.
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.cin   = 1'b0;
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h100);
    n_starts += 2;
    @(negedge clk);
    bus.a = 8'h80;
    bus.b = 8'h80;
    t1 = -1;
    t2 = -1;
    sum_bad = 0;
    for (t = 0; t < 40 && t2 < 0; t++) begin
      if (t1 >= 0 && t == t1 + 1) bus.start = 1'b0;
      if (bus.done) begin
        if (t1 < 0) t1 = t;
        else t2 = t;
      end
      if (t1 >= 0 && t2 < 0 && bus.sum !== 8'h03) sum_bad++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("t4_seen_both", 32'(t1 >= 0 && t2 >= 0), 32'd1);
    check("t4_spacing", 32'(t2 - t1), 32'd9);
    check("t4_sum_hold", 32'(sum_bad), 32'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-RUN aborts without a done.
    d0 = n_done;
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    n_starts--;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_done", 32'(bus.done), 32'd0);
    check("t5_sum", 32'(bus.sum), 32'd0);
    check("t5_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    start_op(8'h0F, 8'h01, 1'b0);
    wait_done();
    check("t5_after_sum", 32'(bus.sum), 32'h10);

    // Random operands with idle gaps.
    for (int i = 0; i < 1000; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("done_count", 32'(n_done), 32'(n_starts));
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
